// File: rtl/sprite_draw_engine.sv
// rtl/sprite_draw_engine.sv - CHIP-8 DXYN sprite draw / 00E0 clear engine with 64x32 framebuffer
//
// Purpose:
//   Executes sprite draws by fetching N bytes from memory starting at I.
//   Each byte is XORed into an internal 64x32 framebuffer. The engine also
//   clears the screen one row per cycle. A combinational read port serves
//   the display scanner.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, cls          one-cycle pulses: begin draw / begin clear
//   x_in, y_in          sprite column / row (taken modulo FB_W / FB_H)
//   n_in, i_in          sprite height in rows, sprite base address
//   mem_addr, mem_data  registered byte address out, byte returned two cycles later
//   busy, done          operation in progress, one-cycle end pulse
//   collision           VF result of the last accepted draw
//   disp_row, disp_data scanner row select, 64-bit row (bit 63 = leftmost pixel)

module sprite_draw_engine #(
    parameter int FB_W   = 64,
    parameter int FB_H   = 32,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cls,
    input  logic [7:0]        x_in,
    input  logic [7:0]        y_in,
    input  logic [3:0]        n_in,
    input  logic [ADDR_W-1:0] i_in,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic              busy,
    output logic              done,
    output logic              collision,
    input  logic [4:0]        disp_row,
    output logic [FB_W-1:0]   disp_data
);

    localparam int XW = $clog2(FB_W);
    localparam int YW = $clog2(FB_H);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_FETCH  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DRAW   = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [XW-1:0]          x_q, x_d;
    logic [YW-1:0]          y_q, y_d;
    logic [3:0]             n_q, n_d;
    logic [ADDR_W-1:0]      base_q, base_d;
    logic [YW-1:0]          row_q, row_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic                   collision_q, collision_d;
    // Framebuffer packed row-major: row r occupies bits [r*FB_W +: FB_W]
    logic [FB_H*FB_W-1:0]   fb_q, fb_d;

    // Upper operand bits are discarded by the modulo wrap of x/y
    logic unused_bits;
    assign unused_bits = ^{x_in[7:XW], y_in[7:YW]};

    // One extra bit so rows that fall off the bottom are detectable
    logic [YW:0]            target_row;
    logic [FB_W-1:0]        old_row;
    logic [FB_W-1:0]        sprite_row;
    logic [YW-1:0]          row_inc;

    assign target_row = {1'b0, y_q} + {1'b0, row_q};
    assign old_row    = fb_q[{target_row[YW-1:0], {XW{1'b0}}} +: FB_W];
    // Right shift drops pixels past the right edge, giving horizontal clipping
    assign sprite_row = {mem_data, {(FB_W-8){1'b0}}} >> x_q;
    assign row_inc    = row_q + 1'b1;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cls) begin
                    state_d = ST_CLEAR;
                end else if (start) begin
                    state_d = (n_in == 4'd0) ? ST_FINISH : ST_FETCH;
                end
            end
            ST_CLEAR:  if (row_q == YW'(FB_H - 1)) state_d = ST_FINISH;
            ST_FETCH:  state_d = ST_WAIT;
            ST_WAIT:   state_d = ST_DRAW;
            ST_DRAW:   state_d = (row_inc == {1'b0, n_q}) ? ST_FINISH : ST_FETCH;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_FINISH);
        mem_addr  = mem_addr_q;
        collision = collision_q;
        disp_data = fb_q[{disp_row, {XW{1'b0}}} +: FB_W];
    end

    // Datapath next-state
    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        n_d         = n_q;
        base_d      = base_q;
        row_d       = row_q;
        mem_addr_d  = mem_addr_q;
        collision_d = collision_q;
        fb_d        = fb_q;
        case (state_q)
            ST_IDLE: begin
                if (cls) begin
                    row_d = '0;
                end else if (start) begin
                    x_d         = x_in[XW-1:0];
                    y_d         = y_in[YW-1:0];
                    n_d         = n_in;
                    base_d      = i_in;
                    row_d       = '0;
                    collision_d = 1'b0;
                end
            end
            ST_CLEAR: begin
                fb_d[{row_q, {XW{1'b0}}} +: FB_W] = '0;
                row_d = row_inc;
            end
            ST_FETCH: begin
                mem_addr_d = base_q + ADDR_W'(row_q);
            end
            ST_DRAW: begin
                if (!target_row[YW]) begin
                    fb_d[{target_row[YW-1:0], {XW{1'b0}}} +: FB_W] = old_row ^ sprite_row;
                    // A lit pixel turns off exactly where old and sprite overlap
                    if ((old_row & sprite_row) != '0) begin
                        collision_d = 1'b1;
                    end
                end
                row_d = row_inc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q         <= '0;
            y_q         <= '0;
            n_q         <= '0;
            base_q      <= '0;
            row_q       <= '0;
            mem_addr_q  <= '0;
            collision_q <= 1'b0;
            fb_q        <= '0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            n_q         <= n_d;
            base_q      <= base_d;
            row_q       <= row_d;
            mem_addr_q  <= mem_addr_d;
            collision_q <= collision_d;
            fb_q        <= fb_d;
        end
    end

endmodule

// File: tb/tb_sprite_draw_engine.sv
// tb/tb_sprite_draw_engine.sv - directed self-checking bench for sprite_draw_engine

module tb_sprite_draw_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        cls = 1'b0;
    logic [7:0]  x_in = 8'd0;
    logic [7:0]  y_in = 8'd0;
    logic [3:0]  n_in = 4'd0;
    logic [11:0] i_in = 12'd0;
    logic [11:0] mem_addr;
    logic [7:0]  mem_data = 8'd0;
    logic        busy;
    logic        done;
    logic        collision;
    logic [4:0]  disp_row = 5'd0;
    logic [63:0] disp_data;

    logic [7:0]  mem [4096];
    logic [11:0] addr_log [2];
    int          checks = 0;
    int          failures = 0;
    int          lat;
    logic        busy_all;
    logic [63:0] acc;

    sprite_draw_engine dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cls       (cls),
        .x_in      (x_in),
        .y_in      (y_in),
        .n_in      (n_in),
        .i_in      (i_in),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .busy      (busy),
        .done      (done),
        .collision (collision),
        .disp_row  (disp_row),
        .disp_data (disp_data)
    );

    always #5 clk = ~clk;

    // Memory unit: registers the address, data valid the following cycle
    always @(posedge clk) mem_data <= mem[mem_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic read_row(input int r, output logic [63:0] v);
        disp_row = 5'(r);
        #1;
        v = disp_data;
    endtask

    // OR of every framebuffer row
    task automatic all_rows(output logic [63:0] v);
        logic [63:0] t;
        v = '0;
        for (int r = 0; r < 32; r++) begin
            read_row(r, t);
            v = v | t;
        end
    endtask

    // Called right after the edge that samples start/cls; latency counts from that edge
    task automatic wait_done(output int l, output logic b);
        int c;
        int idx;
        c = 1;
        idx = 0;
        b = busy;
        while (!done && c < 200) begin
            tick();
            c++;
            b = b & busy;
            if ((c % 3) == 2 && idx < 2) begin
                addr_log[idx] = mem_addr;
                idx++;
            end
        end
        l = done ? c : -1;
    endtask

    task automatic draw(input logic [7:0] x, input logic [7:0] y,
                        input logic [3:0] n, input logic [11:0] i);
        x_in = x; y_in = y; n_in = n; i_in = i;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat, busy_all);
    endtask

    task automatic clear();
        cls = 1'b1;
        tick();
        cls = 1'b0;
        wait_done(lat, busy_all);
    endtask

    logic [63:0] v;

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
        mem[12'h200] = 8'hF0;
        mem[12'h201] = 8'h90;
        mem[12'h300] = 8'hFF;
        mem[12'h301] = 8'hFF;
        mem[12'hFFF] = 8'h81;
        mem[12'h000] = 8'h42;

        // Reset state
        repeat (2) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_coll", collision, 0);
        check("rst_addr", mem_addr, 0);
        rst = 1'b0;
        tick();

        // Clear: 33-cycle latency, busy throughout, screen blank
        clear();
        check("cls_lat", lat, 33);
        check("cls_busy", busy_all, 1);
        tick();
        check("cls_idle", busy, 0);
        all_rows(v);
        check("cls_rows", v, 64'h0);

        // Basic draw
        draw(8'd0, 8'd0, 4'd2, 12'h200);
        check("draw_lat", lat, 7);
        check("draw_addr0", addr_log[0], 12'h200);
        check("draw_addr1", addr_log[1], 12'h201);
        read_row(0, v); check("draw_row0", v, 64'hF000_0000_0000_0000);
        read_row(1, v); check("draw_row1", v, 64'h9000_0000_0000_0000);
        check("draw_coll", collision, 0);
        tick();

        // Redraw erases and collides
        draw(8'd0, 8'd0, 4'd2, 12'h200);
        read_row(0, v); check("redraw_row0", v, 64'h0);
        read_row(1, v); check("redraw_row1", v, 64'h0);
        check("redraw_coll", collision, 1);
        tick();

        // Draw at x=8 on a blank area clears collision
        draw(8'd8, 8'd0, 4'd2, 12'h200);
        read_row(0, v); check("x8_row0", v, 64'h00F0_0000_0000_0000);
        read_row(1, v); check("x8_row1", v, 64'h0090_0000_0000_0000);
        check("x8_coll", collision, 0);
        tick();

        // Modulo and clipping: x=124->60, y=63->31, second row off the bottom
        draw(8'h7C, 8'h3F, 4'd2, 12'h300);
        check("clip_lat", lat, 7);
        read_row(31, v); check("clip_row31", v, 64'h0000_0000_0000_000F);
        read_row(0, v);  check("clip_row0", v, 64'h00F0_0000_0000_0000);
        check("clip_coll", collision, 0);
        tick();

        // Address wrap 0xFFF -> 0x000
        draw(8'd0, 8'd10, 4'd2, 12'hFFF);
        check("wrap_addr0", addr_log[0], 12'hFFF);
        check("wrap_addr1", addr_log[1], 12'h000);
        read_row(10, v); check("wrap_row10", v, 64'h8100_0000_0000_0000);
        read_row(11, v); check("wrap_row11", v, 64'h4200_0000_0000_0000);
        tick();
        draw(8'd0, 8'd10, 4'd2, 12'hFFF);
        check("wrap_coll", collision, 1);
        tick();

        // n=0: immediate done, framebuffer untouched, collision cleared
        draw(8'd0, 8'd0, 4'd0, 12'h200);
        check("n0_lat", lat, 1);
        check("n0_coll", collision, 0);
        check("n0_addr_hold", mem_addr, 12'h000);
        read_row(0, v); check("n0_row0", v, 64'h00F0_0000_0000_0000);
        tick();

        // Collision back to 1, then start during CLEAR is ignored
        draw(8'd8, 8'd0, 4'd1, 12'h200);
        check("pre_cls_coll", collision, 1);
        tick();
        cls = 1'b1;
        tick();
        cls = 1'b0;
        repeat (4) tick();
        x_in = 8'd0; y_in = 8'd0; n_in = 4'd2; i_in = 12'h200;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat, busy_all);
        check("cls_start_lat", lat, 28);
        tick();
        check("cls_start_idle", busy, 0);
        all_rows(v);
        check("cls_start_rows", v, 64'h0);
        check("cls_keeps_coll", collision, 1);

        // start and cls together: clear only
        x_in = 8'd0; y_in = 8'd0; n_in = 4'd1; i_in = 12'h200;
        start = 1'b1;
        cls = 1'b1;
        tick();
        start = 1'b0;
        cls = 1'b0;
        wait_done(lat, busy_all);
        check("both_lat", lat, 33);
        tick();
        check("both_idle", busy, 0);
        read_row(0, v); check("both_row0", v, 64'h0);
        check("both_coll", collision, 1);

        // Reset mid-draw
        draw(8'd0, 8'd0, 4'd2, 12'h200);
        tick();
        x_in = 8'd0; y_in = 8'd0; n_in = 4'd2; i_in = 12'h200;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        read_row(0, v); check("mid_row0", v, 64'h0);
        read_row(1, v); check("mid_row1", v, 64'h9000_0000_0000_0000);
        check("mid_coll", collision, 1);
        check("mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_coll", collision, 0);
        check("abort_done", done, 0);
        all_rows(v);
        check("abort_rows", v, 64'h0);
        repeat (2) tick();
        rst = 1'b0;
        acc = '0;
        for (int k = 0; k < 10; k++) begin
            tick();
            acc = acc | {62'd0, busy, done};
        end
        check("abort_quiet", acc, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sprite_draw_engine.md
Name: sprite_draw_engine

Overview:
Executes the CHIP-8 DXYN (draw sprite) and 00E0 (clear screen) operations on the display framebuffer. It sits directly downstream of the memory unit. It issues byte addresses starting at I, consumes the sprite bytes returned, and XORs them into an internal 64x32 framebuffer. A separate read port lets the display scanner fetch one 64-bit row at a time. The control unit starts operations and waits for done before committing VF.

Parameters:
FB_W, 64, framebuffer width in pixels (fixed, power of 2)
FB_H, 32, framebuffer height in rows (fixed, power of 2)
ADDR_W, 12, memory address width (4096-byte space)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: begin DXYN draw
cls  in  1  one-cycle pulse: begin screen clear
x_in  in  8  VX value (sprite column)
y_in  in  8  VY value (sprite row)
n_in  in  4  sprite height in rows (N)
i_in  in  12  I register (sprite base address)
mem_addr  out  12  byte address to memory unit (registered)
mem_data  in  8  byte returned by memory unit
busy  out  1  operation in progress
done  out  1  one-cycle pulse at operation end
collision  out  1  VF result of last draw
disp_row  in  5  display scanner row select
disp_data  out  64  framebuffer row disp_row, bit 63 = leftmost pixel (combinational read)

Behaviour:
- Reset (async): state IDLE; mem_addr=0, busy=0, done=0, collision=0; all 2048 framebuffer bits cleared.
- States: IDLE, CLEAR, FETCH, WAIT, DRAW, FINISH.
- IDLE: cls has priority over start if both are high. On cls: row counter=0, goto CLEAR. On start: latch x=x_in mod 64, y=y_in mod 32, n=n_in, base=i_in; clear collision; row=0. If n=0, goto FINISH; else goto FETCH.
- start/cls while busy=1: ignored, with no effect on the latched operands.
- CLEAR: zero one row per cycle (row 0..31). Exit to FINISH after row 31. Total 32 cycles in CLEAR.
- FETCH: mem_addr <= (base + row) mod 4096 (wraps at 4095->0). Goto WAIT.
- WAIT: memory unit registers the address. Goto DRAW.
- DRAW: mem_data is valid this cycle.
  - Sprite bit 7 maps to column x, bit 6 to column x+1, and so on.
  - Pixels with column >= 64 are clipped (no horizontal wrap).
  - Target row = y + row; if it is >= 32 the row is clipped entirely (no vertical wrap, no collision contribution).
  - Otherwise row <= row XOR shifted sprite.
  - collision is set if any bit was 1 before and 0 after.
  - row++. If row == n, goto FINISH; else goto FETCH.
- FINISH: done=1 for exactly this cycle, busy=0 next cycle, goto IDLE.
- busy=1 in all states except IDLE, and is asserted the cycle after start/cls is sampled.
- Latency, start edge to done pulse:
  - draw: 3N+1 cycles
  - n=0: 1 cycle
  - clear: 33 cycles
- collision is sticky until the next accepted start. cls does not change it.
- mem_addr holds its last value in IDLE/CLEAR/FINISH.
- disp_data reflects framebuffer contents after the most recent rising edge, including mid-draw partial rows.
- Reset mid-operation aborts immediately. No done pulse is generated, and the framebuffer is cleared.

Test Plan:
- Reset then cls: rst pulse, cls -> done 33 cycles later; every disp_row 0..31 reads 64'h0; busy high throughout.
- Basic draw: mem[0x200]=8'hF0, [0x201]=8'h90, x=0, y=0, n=2, i=0x200 -> mem_addr 0x200 then 0x201; done at cycle 7; row0=64'hF000...0, row1=64'h9000...0; collision=0.
- Collision: repeat the same draw -> rows 0,1 return to 0; collision=1. Draw again at x=8 -> collision=0.
- Clipping/modulo: x=8'h7C (60), y=8'h3F (31), n=2, byte 8'hFF -> row31 low nibble = 4'hF, columns 64+ dropped; row 0 unchanged.
- Address wrap and n=0: i=0xFFF, n=2 -> mem_addr 0xFFF then 0x000. n=0 -> done 1 cycle after start, framebuffer unchanged, collision=0.
- Contention: start during CLEAR is ignored; start+cls in the same cycle runs a clear only. rst asserted mid-draw -> busy=0, collision=0, and all rows zero immediately.
